// File: rtl/rns_to_bin_conv.sv
// Reverse converter: residues (mod 129, mod 256) to a 16-bit binary value.
// Uses CRT X = r256 + 256*t, with t = (r129 - r256) * 64 mod 129.
module rns_to_bin_conv #(
  parameter int TAG_W     = 3,
  parameter bit CHK_RANGE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       res_129,
  input  logic [7:0]       res_256,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      dout,
  output logic [TAG_W-1:0] tag_out,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DBL  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       r129_q, r129_d;
  logic [7:0]       r256_q, r256_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             err_r_q, err_r_d;
  logic [7:0]       v_q, v_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [15:0]      dout_q, dout_d;
  logic [TAG_W-1:0] tag_out_q, tag_out_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;

  logic [7:0] m;
  logic [9:0] diff;
  logic [7:0] d_adj;
  logic [8:0] dbl2;
  logic [7:0] dbl;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign tag_out   = tag_out_q;
  assign err       = err_q;

  always_comb begin
    m     = (r256_q >= 8'd129) ? 8'(r256_q - 8'd129) : r256_q;
    diff  = {2'b00, r129_q} - {2'b00, m};
    d_adj = diff[9] ? 8'(diff + 10'd129) : 8'(diff);
    dbl2  = {v_q, 1'b0};
    dbl   = (dbl2 >= 9'd129) ? 8'(dbl2 - 9'd129) : 8'(dbl2);
  end

  always_comb begin
    state_d     = state_q;
    r129_d      = r129_q;
    r256_d      = r256_q;
    tag_d       = tag_q;
    err_r_d     = err_r_q;
    v_d         = v_q;
    cnt_d       = cnt_q;
    dout_d      = dout_q;
    tag_out_d   = tag_out_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          r129_d  = res_129;
          r256_d  = res_256;
          tag_d   = tag_in;
          err_r_d = CHK_RANGE && (res_129 >= 8'd129);
          state_d = SUB;
        end
      end
      SUB: begin
        v_d     = err_r_q ? 8'd0 : d_adj;
        cnt_d   = 3'd0;
        state_d = DBL;
      end
      DBL: begin
        v_d   = dbl;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd5) begin
          dout_d      = err_r_q ? 16'd0
                      : {dbl, 8'h00} + {8'h00, r256_q};
          tag_out_d   = tag_q;
          err_d       = err_r_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over everything but reset; data outputs are kept.
    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      err_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      r129_q      <= '0;
      r256_q      <= '0;
      tag_q       <= '0;
      err_r_q     <= 1'b0;
      v_q         <= '0;
      cnt_q       <= '0;
      dout_q      <= '0;
      tag_out_q   <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r129_q      <= r129_d;
      r256_q      <= r256_d;
      tag_q       <= tag_d;
      err_r_q     <= err_r_d;
      v_q         <= v_d;
      cnt_q       <= cnt_d;
      dout_q      <= dout_d;
      tag_out_q   <= tag_out_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
